// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer trigger path: sequencer states,
// config register addresses and trig-unit command field encodings.
package la_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_WAIT,
    ST_POST,
    ST_DONE
  } state_t;

  localparam logic [3:0] ADDR_CMD0 = 4'h0;
  localparam logic [3:0] ADDR_OCC0 = 4'h4;
  localparam logic [3:0] ADDR_LAST = 4'h8;
  localparam logic [3:0] ADDR_PRE  = 4'h9;
  localparam logic [3:0] ADDR_POST = 4'hA;
  localparam logic [3:0] ADDR_TMO  = 4'hB;

  // trig unit command nibble: {enable, compare, mode[1:0]}
  localparam int CMD_EN_BIT  = 3;
  localparam int CMD_CMP_BIT = 2;
  localparam logic [1:0] MODE_LOW  = 2'b00;
  localparam logic [1:0] MODE_POS  = 2'b01;
  localparam logic [1:0] MODE_NEGE = 2'b10;
  localparam logic [1:0] MODE_HIGH = 2'b11;

  function automatic logic [3:0] trig_cmd(input logic en, input logic cmp,
                                          input logic [1:0] mode);
    return {en, cmp, mode};
  endfunction

endpackage

// File: rtl/trig_cfg_regs.sv
// Trigger sequencer config register file; writes are dropped while busy.
// Register 0xB (TIMEOUT) exists only when TRIG_TIMEOUT_EN is defined.
module trig_cfg_regs
  import la_pkg::*;
#(
  parameter int NCH  = 8,
  parameter int NSTG = 4,
  parameter int CNTW = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       we_i,
  input  logic [3:0]                 addr_i,
  input  logic [31:0]                data_i,
  input  logic                       busy_i,
  output logic [NSTG-1:0][NCH*4-1:0] cmd_o,
  output logic [NSTG-1:0][CNTW-1:0]  occ_o,
  output logic [1:0]                 last_o,
  output logic [CNTW-1:0]            pre_o,
  output logic [CNTW-1:0]            post_o
`ifdef TRIG_TIMEOUT_EN
 ,output logic [CNTW-1:0]            tmo_o
`endif
);

  logic [NSTG-1:0][NCH*4-1:0] cmd_q;
  logic [NSTG-1:0][CNTW-1:0]  occ_q;
  logic [1:0]                 last_q;
  logic [CNTW-1:0]            pre_q;
  logic [CNTW-1:0]            post_q;
`ifdef TRIG_TIMEOUT_EN
  logic [CNTW-1:0]            tmo_q;
`endif

  logic wr_ok;
  assign wr_ok = we_i && !busy_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_q  <= '0;
      occ_q  <= '0;
      last_q <= '0;
      pre_q  <= '0;
      post_q <= '0;
`ifdef TRIG_TIMEOUT_EN
      tmo_q  <= '0;
`endif
    end else if (wr_ok) begin
      // stage slots beyond NSTG are left undecoded
      for (int s = 0; s < NSTG; s++) begin
        if (addr_i == ADDR_CMD0 + 4'(s)) cmd_q[s] <= data_i[NCH*4-1:0];
        if (addr_i == ADDR_OCC0 + 4'(s)) occ_q[s] <= data_i[CNTW-1:0];
      end
      if (addr_i == ADDR_LAST) last_q <= data_i[1:0];
      if (addr_i == ADDR_PRE)  pre_q  <= data_i[CNTW-1:0];
      if (addr_i == ADDR_POST) post_q <= data_i[CNTW-1:0];
`ifdef TRIG_TIMEOUT_EN
      if (addr_i == ADDR_TMO)  tmo_q  <= data_i[CNTW-1:0];
`endif
    end
  end

  assign cmd_o  = cmd_q;
  assign occ_o  = occ_q;
  assign last_o = last_q;
  assign pre_o  = pre_q;
  assign post_o = post_q;
`ifdef TRIG_TIMEOUT_EN
  assign tmo_o  = tmo_q;
`endif

endmodule

// File: rtl/trig_ctrl.sv
// Multi-stage trigger sequencer driving a bank of trig units.
// Optional WAIT timeout / force-trigger enabled by TRIG_TIMEOUT_EN.
module trig_ctrl
  import la_pkg::*;
#(
  parameter int NCH  = 8,
  parameter int NSTG = 4,
  parameter int CNTW = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CfgWE,
  input  logic [3:0]       CfgAddr,
  input  logic [31:0]      CfgData,
  input  logic             Start,
  input  logic             Abort,
  input  logic [NCH-1:0]   ResTri,
  output logic [NCH*4-1:0] TrigCmd,
  output logic [NCH-1:0]   TrigWE,
  output logic             TrigInit,
  output logic             TrigEN,
  output logic             CapEn,
  output logic             Busy,
  output logic             Triggered,
  output logic             Done,
  output logic [1:0]       Stage,
  output logic [CNTW-1:0]  TrigPos
);

  logic [NSTG-1:0][NCH*4-1:0] cfg_cmd;
  logic [NSTG-1:0][CNTW-1:0]  cfg_occ;
  logic [1:0]                 cfg_last;
  logic [CNTW-1:0]            cfg_pre;
  logic [CNTW-1:0]            cfg_post;
`ifdef TRIG_TIMEOUT_EN
  logic [CNTW-1:0]            cfg_tmo;
  logic [CNTW-1:0]            tmo_cnt_q, tmo_cnt_d;
`endif

  state_t            state_q, state_d;
  logic [1:0]        stage_q, stage_d;
  logic [CNTW-1:0]   cap_cnt_q, cap_cnt_d;
  logic [CNTW-1:0]   mcnt_q, mcnt_d;
  logic [CNTW-1:0]   post_cnt_q, post_cnt_d;
  logic [CNTW-1:0]   trig_pos_q, trig_pos_d;
  logic              triggered_q, triggered_d;
  logic              done_q, done_d;
  logic              init_q, init_d;
  logic              en_q, en_d;
  logic              cap_en_q, cap_en_d;
  logic              busy_q, busy_d;
  logic [NCH-1:0]    we_q, we_d;
  logic [NCH*4-1:0]  cmd_q, cmd_d;
  logic              start_q, start_d;
  logic              abort_q, abort_d;
  logic              res_and_q, res_and_d;
  logic              samp_vld_q, samp_vld_d;
  logic [CNTW-1:0]   samp_cnt_q, samp_cnt_d;

  logic [1:0]        last_eff;
  logic              match;
  logic              sat;
  logic              fire;
  logic              forced;

  trig_cfg_regs #(
    .NCH  (NCH),
    .NSTG (NSTG),
    .CNTW (CNTW)
  ) u_regs (
    .clk_i  (CLK),
    .rst_i  (RST),
    .we_i   (CfgWE),
    .addr_i (CfgAddr),
    .data_i (CfgData),
    .busy_i (busy_q),
    .cmd_o  (cfg_cmd),
    .occ_o  (cfg_occ),
    .last_o (cfg_last),
    .pre_o  (cfg_pre),
    .post_o (cfg_post)
`ifdef TRIG_TIMEOUT_EN
   ,.tmo_o  (cfg_tmo)
`endif
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      stage_q     <= '0;
      cap_cnt_q   <= '0;
      mcnt_q      <= '0;
      post_cnt_q  <= '0;
      trig_pos_q  <= '0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      init_q      <= 1'b0;
      en_q        <= 1'b0;
      cap_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      we_q        <= '0;
      cmd_q       <= '0;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      res_and_q   <= 1'b0;
      samp_vld_q  <= 1'b0;
      samp_cnt_q  <= '0;
`ifdef TRIG_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      cap_cnt_q   <= cap_cnt_d;
      mcnt_q      <= mcnt_d;
      post_cnt_q  <= post_cnt_d;
      trig_pos_q  <= trig_pos_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
      init_q      <= init_d;
      en_q        <= en_d;
      cap_en_q    <= cap_en_d;
      busy_q      <= busy_d;
      we_q        <= we_d;
      cmd_q       <= cmd_d;
      start_q     <= start_d;
      abort_q     <= abort_d;
      res_and_q   <= res_and_d;
      samp_vld_q  <= samp_vld_d;
      samp_cnt_q  <= samp_cnt_d;
`ifdef TRIG_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    cap_cnt_d   = cap_cnt_q;
    mcnt_d      = mcnt_q;
    post_cnt_d  = post_cnt_q;
    trig_pos_d  = trig_pos_q;
    triggered_d = triggered_q;
    done_d      = done_q;
    init_d      = 1'b0;
    cmd_d       = cmd_q;
    fire        = 1'b0;
    forced      = 1'b0;
`ifdef TRIG_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif

    // Inputs and the ResTri sample are registered; a sample counts only if it
    // was taken in WAIT and the FSM is still in WAIT when it is evaluated.
    start_d    = Start;
    abort_d    = Abort;
    res_and_d  = &ResTri;
    samp_vld_d = (state_q == ST_WAIT);
    samp_cnt_d = cap_cnt_q;

    last_eff = cfg_last & 2'(NSTG - 1);
    match    = (state_q == ST_WAIT) && samp_vld_q && res_and_q &&
               (samp_cnt_q >= cfg_pre);
    sat      = match && (mcnt_q == cfg_occ[stage_q]);

    if (cap_en_q && (cap_cnt_q != '1)) cap_cnt_d = cap_cnt_q + CNTW'(1);

    if (abort_q) begin
      state_d     = ST_IDLE;
      stage_d     = '0;
      triggered_d = 1'b0;
      done_d      = 1'b0;
      init_d      = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_q) begin
            state_d     = ST_LOAD;
            stage_d     = '0;
            cap_cnt_d   = '0;
            post_cnt_d  = '0;
            triggered_d = 1'b0;
            done_d      = 1'b0;
          end
        end
        ST_LOAD: begin
          state_d = ST_ARM;
          mcnt_d  = '0;
`ifdef TRIG_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
        ST_ARM: state_d = ST_WAIT;
        ST_WAIT: begin
          if (sat) begin
            if (stage_q < last_eff) begin
              stage_d = stage_q + 2'd1;
              state_d = ST_LOAD;
            end else begin
              fire       = 1'b1;
              trig_pos_d = samp_cnt_q;
            end
          end else if (match) begin
            mcnt_d = mcnt_q + CNTW'(1);
          end
`ifdef TRIG_TIMEOUT_EN
          tmo_cnt_d = tmo_cnt_q + CNTW'(1);
          if (!sat && (cfg_tmo != '0) && (tmo_cnt_q == cfg_tmo - CNTW'(1))) begin
            fire       = 1'b1;
            forced     = 1'b1;
            trig_pos_d = cap_cnt_q;
          end
`endif
          if (fire) begin
            triggered_d = 1'b1;
            post_cnt_d  = '0;
            if ((cfg_post == '0) && !forced) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              init_d  = 1'b1;
            end else begin
              state_d = ST_POST;
            end
          end
        end
        ST_POST: begin
          if (post_cnt_q == cfg_post) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            init_d  = 1'b1;
          end else begin
            post_cnt_d = post_cnt_q + CNTW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    en_d     = (state_d == ST_ARM) || (state_d == ST_WAIT);
    busy_d   = state_d inside {ST_LOAD, ST_ARM, ST_WAIT, ST_POST};
    cap_en_d = (state_d inside {ST_ARM, ST_WAIT, ST_POST}) ||
               ((state_d == ST_LOAD) && (stage_d != '0));
    we_d     = (state_d == ST_LOAD) ? '1 : '0;
    if (state_d == ST_LOAD) cmd_d = cfg_cmd[stage_d];
  end

  assign TrigCmd   = cmd_q;
  assign TrigWE    = we_q;
  assign TrigInit  = init_q;
  assign TrigEN    = en_q;
  assign CapEn     = cap_en_q;
  assign Busy      = busy_q;
  assign Triggered = triggered_q;
  assign Done      = done_q;
  assign Stage     = stage_q;
  assign TrigPos   = trig_pos_q;

endmodule

// File: tb/tb_trig_ctrl.sv
// Directed bench for trig_ctrl; the timeout case follows TRIG_TIMEOUT_EN.
module tb_trig_ctrl;

  localparam int NCH  = 8;
  localparam int NSTG = 4;
  localparam int CNTW = 16;

  logic             CLK = 1'b0;
  logic             RST;
  logic             CfgWE;
  logic [3:0]       CfgAddr;
  logic [31:0]      CfgData;
  logic             Start;
  logic             Abort;
  logic [NCH-1:0]   ResTri;
  logic [NCH*4-1:0] TrigCmd;
  logic [NCH-1:0]   TrigWE;
  logic             TrigInit;
  logic             TrigEN;
  logic             CapEn;
  logic             Busy;
  logic             Triggered;
  logic             Done;
  logic [1:0]       Stage;
  logic [CNTW-1:0]  TrigPos;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  trig_ctrl #(.NCH(NCH), .NSTG(NSTG), .CNTW(CNTW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CfgWE     (CfgWE),
    .CfgAddr   (CfgAddr),
    .CfgData   (CfgData),
    .Start     (Start),
    .Abort     (Abort),
    .ResTri    (ResTri),
    .TrigCmd   (TrigCmd),
    .TrigWE    (TrigWE),
    .TrigInit  (TrigInit),
    .TrigEN    (TrigEN),
    .CapEn     (CapEn),
    .Busy      (Busy),
    .Triggered (Triggered),
    .Done      (Done),
    .Stage     (Stage),
    .TrigPos   (TrigPos)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the rising edge just taken.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg_wr(input logic [3:0] a, input logic [31:0] d);
    CfgWE = 1'b1; CfgAddr = a; CfgData = d;
    tick();
    CfgWE = 1'b0;
  endtask

  // Returns just after the edge that samples Start (edge 0).
  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; CfgWE = 1'b0; CfgAddr = '0; CfgData = '0;
    Start = 1'b0; Abort = 1'b0; ResTri = '1;
    ticks(2);
    chk("rst_busy",  Busy,      0);
    chk("rst_cmd",   TrigCmd,   0);
    chk("rst_we",    TrigWE,    0);
    chk("rst_init",  TrigInit,  0);
    chk("rst_en",    TrigEN,    0);
    chk("rst_capen", CapEn,     0);
    chk("rst_trig",  Triggered, 0);
    chk("rst_done",  Done,      0);
    chk("rst_stage", Stage,     0);
    chk("rst_pos",   TrigPos,   0);
    RST = 1'b0;
    tick();

    // T1: disabled units, PRE=5, POST=3
    cfg_wr(4'h9, 32'd5);
    cfg_wr(4'hA, 32'd3);
    ResTri = 8'hFF;
    pulse_start();
    chk("t1_busy_e0", Busy, 0);
    tick();
    chk("t1_busy_e1",  Busy,   1);
    chk("t1_we_e1",    TrigWE, 8'hFF);
    chk("t1_en_e1",    TrigEN, 0);
    chk("t1_capen_e1", CapEn,  0);
    tick();
    chk("t1_en_e2",    TrigEN, 1);
    chk("t1_capen_e2", CapEn,  1);
    chk("t1_we_e2",    TrigWE, 0);
    ticks(6);
    chk("t1_trig_e8", Triggered, 0);
    tick();
    chk("t1_trig_e9", Triggered, 1);
    chk("t1_pos_e9",  TrigPos,   5);
    ticks(3);
    chk("t1_done_e12", Done, 0);
    tick();
    chk("t1_done_e13",  Done,     1);
    chk("t1_init_e13",  TrigInit, 1);
    chk("t1_busy_e13",  Busy,     0);
    chk("t1_capen_e13", CapEn,    0);
    tick();
    chk("t1_init_e14", TrigInit,  0);
    chk("t1_trig_e14", Triggered, 1);

    // T2: stage 0 ch0 Pos, stage 1 ch1 High
    cfg_wr(4'h0, 32'h0000_000D);
    cfg_wr(4'h1, 32'h0000_00F0);
    cfg_wr(4'h8, 32'd1);
    cfg_wr(4'h9, 32'd0);
    cfg_wr(4'hA, 32'd0);
    ResTri = 8'hFE;
    pulse_start();
    tick();
    chk("t2_cmd_e1",   TrigCmd,   32'h0000_000D);
    chk("t2_we_e1",    TrigWE,    8'hFF);
    chk("t2_stage_e1", Stage,     0);
    chk("t2_trig_e1",  Triggered, 0);
    ticks(5);
    chk("t2_stage_e6", Stage, 0);
    ResTri = 8'hFF;
    tick();
    chk("t2_trig_e7", Triggered, 0);
    ResTri = 8'hFD;
    tick();
    chk("t2_stage_e8", Stage,   1);
    chk("t2_cmd_e8",   TrigCmd, 32'h0000_00F0);
    chk("t2_we_e8",    TrigWE,  8'hFF);
    chk("t2_capen_e8", CapEn,   1);
    chk("t2_en_e8",    TrigEN,  0);
    ticks(4);
    chk("t2_trig_e12", Triggered, 0);
    ResTri = 8'hFF;
    tick();
    chk("t2_trig_e13", Triggered, 0);
    tick();
    chk("t2_trig_e14", Triggered, 1);
    chk("t2_done_e14", Done,      1);
    chk("t2_pos_e14",  TrigPos,   10);

    // T3: OCC=2 on ch0 Pos, pulses sampled at edges 5, 8, 11
    cfg_wr(4'h8, 32'd0);
    cfg_wr(4'h4, 32'd2);
    cfg_wr(4'hA, 32'd2);
    ResTri = 8'hFE;
    pulse_start();
    for (int e = 1; e <= 16; e++) begin
      ResTri = (e == 5 || e == 8 || e == 11) ? 8'hFF : 8'hFE;
      tick();
      if (e == 9)  chk("t3_trig_e9",  Triggered, 0);
      if (e == 11) chk("t3_trig_e11", Triggered, 0);
      if (e == 12) begin
        chk("t3_trig_e12", Triggered, 1);
        chk("t3_pos_e12",  TrigPos,   8);
      end
      if (e == 14) chk("t3_done_e14", Done, 0);
      if (e == 15) chk("t3_done_e15", Done, 1);
    end

    // T4: Abort+Start during WAIT, blocked write while busy
    cfg_wr(4'h0, 32'h0);
    cfg_wr(4'h4, 32'h0);
    cfg_wr(4'h9, 32'd12);
    cfg_wr(4'hA, 32'd0);
    ResTri = 8'hFF;
    pulse_start();
    ticks(5);
    chk("t4_busy_e5", Busy, 1);
    cfg_wr(4'h9, 32'd3);
    Abort = 1'b1; Start = 1'b1;
    tick();
    Abort = 1'b0; Start = 1'b0;
    tick();
    chk("t4_busy_ab",  Busy,      0);
    chk("t4_init_ab",  TrigInit,  1);
    chk("t4_en_ab",    TrigEN,    0);
    chk("t4_capen_ab", CapEn,     0);
    chk("t4_trig_ab",  Triggered, 0);
    chk("t4_done_ab",  Done,      0);
    chk("t4_stage_ab", Stage,     0);
    tick();
    chk("t4_init_ab1", TrigInit, 0);
    chk("t4_busy_ab1", Busy,     0);
    pulse_start();
    ticks(15);
    chk("t4_trig_e15", Triggered, 0);
    tick();
    chk("t4_trig_e16", Triggered, 1);
    chk("t4_pos_e16",  TrigPos,   12);

    // T5: TIMEOUT=10 with ResTri held low
    cfg_wr(4'hB, 32'd10);
    cfg_wr(4'h9, 32'd0);
    ResTri = 8'h00;
    pulse_start();
    ticks(12);
    chk("t5_trig_e12", Triggered, 0);
    chk("t5_busy_e12", Busy,      1);
    tick();
`ifdef TRIG_TIMEOUT_EN
    chk("t5_trig_e13", Triggered, 1);
    chk("t5_pos_e13",  TrigPos,   10);
    chk("t5_busy_e13", Busy,      1);
    tick();
    chk("t5_done_e14", Done, 1);
`else
    ticks(40);
    chk("t5_busy_e53", Busy,      1);
    chk("t5_trig_e53", Triggered, 0);
`endif
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    tick();
    chk("t5_busy_end", Busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
